mem_access_unit: RTL

// - Memory stage downstream of the execute unit: uses ALU_Result as the effective address, Read_data_2 as store data.
// - Runs byte/half/word loads and stores over a req/ack data bus, sign- or zero-extends load data for writeback.
// - Stalls the single-cycle core until the access completes or times out.

---
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: byte/half/word loads and stores over a req/ack bus
//
// Purpose: takes the effective address (ALU_Result) and store data (Read_data_2)
// from the execute unit. It runs one bus transfer per aligned load or store and
// stalls the core until the transfer completes or times out. Load data is
// sign- or zero-extended for writeback.
//
// Ports:
//   clock, reset                      clock and asynchronous active-low reset
//   Mem_read, Mem_write               access request (write wins when both are high)
//   Mem_size, Load_unsigned           00 byte, 01 half, 1x word; zero-extend loads
//   ALU_Result, Read_data_2           effective address, store data
//   bus_req/we/addr/be/wdata          bus request side, held stable while in REQ
//   bus_ack, bus_rdata                transfer completion and read data
//   Stall                             hold PC/register file while high
//   Read_data                         extended load result, held until the next load
//   Addr_error, Bus_error             one-cycle error pulses
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Mem_read,
  input  logic        Mem_write,
  input  logic [1:0]  Mem_size,
  input  logic        Load_unsigned,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Read_data_2,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        Stall,
  output logic [31:0] Read_data,
  output logic        Addr_error,
  output logic        Bus_error
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lo_q, lo_d;     // address bits [1:0], dropped from bus_addr but needed for lane select
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              aerr_q, aerr_d;
  logic              berr_q, berr_d;

  logic              access, misaligned, start, timeout_hit;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new, load_ext;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  // Request decode from the current instruction
  always_comb begin
    access = Mem_read | Mem_write;
    case (Mem_size)
      2'b00: begin
        be_new     = 4'b0001 << ALU_Result[1:0];
        wdata_new  = {4{Read_data_2[7:0]}};
        misaligned = 1'b0;
      end
      2'b01: begin
        be_new     = ALU_Result[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{Read_data_2[15:0]}};
        misaligned = ALU_Result[0];
      end
      default: begin
        be_new     = 4'b1111;
        wdata_new  = Read_data_2;
        misaligned = |ALU_Result[1:0];
      end
    endcase
    start = access & ~misaligned;
  end

  // Load lane extraction from the latched size and address
  always_comb begin
    lane_b = 8'(bus_rdata >> {lo_q, 3'b000});
    lane_h = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  // The counter holds the number of REQ cycles already spent without ack
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (bus_ack || timeout_hit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. DONE drops Stall so the core advances exactly once per access.
  always_comb begin
    bus_req = (state_q == S_REQ);
    Stall   = (state_q == S_REQ) || ((state_q == S_IDLE) && start);
  end

  // Datapath next values
  always_comb begin
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        aerr_d = access & misaligned;
        if (start) begin
          addr_d  = {ALU_Result[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          we_d    = Mem_write;
          size_d  = Mem_size;
          uns_d   = Load_unsigned;
          lo_d    = ALU_Result[1:0];
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          if (!we_q) rdata_d = load_ext;
        end else if (timeout_hit) begin
          berr_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      lo_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
    end
  end

  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign Read_data  = rdata_q;
  assign Addr_error = aerr_q;
  assign Bus_error  = berr_q;

endmodule
